// File: rtl/mult_div_issue_tracker_pkg.sv
// Shared definitions for the multiply/divide issue tracker.
// Holds the instruction field positions, the opcode/aluop values that select
// mul and div, the nop word used for empty slots, and the divide FSM state
// encodings. It also provides small helpers for decoding instruction words.
package mult_div_issue_tracker_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_MSB     = 26;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned ALUOP_MSB  = 6;
  localparam int unsigned ALUOP_LSB  = 2;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [WORD_W-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic is_mul_word(input logic [WORD_W-1:0] w);
    return (w[OPCODE_MSB:OPCODE_LSB] == OP_ALU) && (w[ALUOP_MSB:ALUOP_LSB] == ALU_MUL);
  endfunction

  function automatic logic is_div_word(input logic [WORD_W-1:0] w);
    return (w[OPCODE_MSB:OPCODE_LSB] == OP_ALU) && (w[ALUOP_MSB:ALUOP_LSB] == ALU_DIV);
  endfunction

  function automatic logic [4:0] rd_of(input logic [WORD_W-1:0] w);
    return w[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/mult_slot_shifter.sv
// Shift register of multiply slots (valid bit plus 32-bit instruction word).
// Index 0 is slot 1, which is the youngest slot. An empty slot always carries
// the nop word, so the exported slot words can be used directly.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high; clears all slots
//   flush      in   clears all slots at the next edge
//   stall      in   holds every slot unchanged
//   in_valid   in   a new multiply enters slot 1 at this edge
//   in_word    in   instruction word of the new multiply
//   slot_valid out  per-slot valid bits
//   slot_word  out  per-slot instruction words
module mult_slot_shifter
  import mult_div_issue_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          stall,
  input  logic                          in_valid,
  input  logic [WORD_W-1:0]             in_word,
  output logic [DEPTH-1:0]              slot_valid,
  output logic [DEPTH-1:0][WORD_W-1:0]  slot_word
);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      slot_valid <= '0;
      slot_word  <= '0;
    end else if (!stall) begin
      slot_valid <= {slot_valid[DEPTH-2:0], in_valid};
      slot_word  <= {slot_word[DEPTH-2:0], (in_valid ? in_word : NOP_WORD)};
    end
  end

endmodule

// File: rtl/mult_div_issue_tracker.sv
// Tracker for the multiply and divide operations that are in flight.
// It accepts mul and div instructions from decode. A multiply shifts through
// MULT_LAT pipelined slots and then enters a writeback register. A divide
// runs alone for DIV_LAT cycles. The tracker exports the four youngest slot
// words and the "mult in flight" flag that decode uses for its stall check.
// MULT_LAT must be at least 4, because four slots are always exported.
// Ports:
//   clock, reset                    clock and synchronous active-high reset
//   issue_valid/instruction/ready   issue handshake with decode
//   flush                           squashes all in-flight ops at the next edge
//   mult_start, mult_is_div         one-cycle start pulse to the multdiv datapath
//   instruction_1..4                slot words, slot 1 is the youngest; 0 when empty
//   mult_ins_signal                 any multiply slot valid or divide busy
//   wb_valid, wb_rd, wb_ready       writeback handshake for completed ops
//
// Divide FSM
//   state    | meaning
//   DIV_IDLE | no divide in flight; multiplies may issue
//   DIV_RUN  | divide executing; counter runs 1..DIV_LAT; word shown on instruction_1
//   DIV_DONE | divide result presented on wb; waiting for wb_ready
module mult_div_issue_tracker
  import mult_div_issue_tracker_pkg::*;
#(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32,
  parameter int unsigned CNT_W    = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [WORD_W-1:0] issue_instruction,
  output logic              issue_ready,
  input  logic              flush,
  output logic              mult_start,
  output logic              mult_is_div,
  output logic [WORD_W-1:0] instruction_1,
  output logic [WORD_W-1:0] instruction_2,
  output logic [WORD_W-1:0] instruction_3,
  output logic [WORD_W-1:0] instruction_4,
  output logic              mult_ins_signal,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  input  logic              wb_ready
);

  logic [MULT_LAT-1:0]             slot_valid;
  logic [MULT_LAT-1:0][WORD_W-1:0] slot_word;

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] div_word_q, div_word_d;

  logic       wb_valid_q;
  logic [4:0] wb_rd_q;

  logic req_mul, req_div;
  logic freeze, div_busy, any_mul;
  logic accept, mul_accept, div_accept, div_finish;

  assign req_mul  = is_mul_word(issue_instruction);
  assign req_div  = is_div_word(issue_instruction);

  // A result waiting on writeback stalls every stage behind it.
  assign freeze   = wb_valid_q & ~wb_ready;
  assign div_busy = (state_q != DIV_IDLE);
  assign any_mul  = |slot_valid;

  // This signal depends on the offered word. A divide must wait until the
  // multiply slots drain, but a multiply can still enter behind them.
  assign issue_ready = ~div_busy & ~freeze & ~(issue_valid & req_div & any_mul);

  assign accept     = issue_valid & issue_ready & (req_mul | req_div) & ~flush & ~reset;
  assign mul_accept = accept & req_mul;
  assign div_accept = accept & req_div;
  assign div_finish = (state_q == DIV_RUN) && (cnt_q == CNT_W'(DIV_LAT));

  mult_slot_shifter #(
    .DEPTH (MULT_LAT)
  ) u_slots (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .stall      (freeze),
    .in_valid   (mul_accept),
    .in_word    (issue_instruction),
    .slot_valid (slot_valid),
    .slot_word  (slot_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_word_d = div_word_q;
    case (state_q)
      DIV_IDLE: begin
        if (div_accept) begin
          state_d    = DIV_RUN;
          cnt_d      = CNT_W'(1);
          div_word_d = issue_instruction;
        end
      end
      DIV_RUN: begin
        if (div_finish) begin
          state_d = DIV_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV_DONE: begin
        if (wb_ready) begin
          state_d    = DIV_IDLE;
          div_word_d = NOP_WORD;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      div_word_q <= NOP_WORD;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_word_q <= div_word_d;
    end
  end

  // The writeback register is shared by both units. The multiply slots are
  // always empty while a divide runs, so the divide load and the slot shift
  // never compete for this register.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
    end else if (div_finish) begin
      wb_valid_q <= 1'b1;
      wb_rd_q    <= rd_of(div_word_q);
    end else if (!freeze) begin
      wb_valid_q <= slot_valid[MULT_LAT-1];
      wb_rd_q    <= rd_of(slot_word[MULT_LAT-1]);
    end
  end

  assign mult_start      = accept;
  assign mult_is_div     = div_accept;
  assign instruction_1   = (state_q == DIV_RUN) ? div_word_q : slot_word[0];
  assign instruction_2   = slot_word[1];
  assign instruction_3   = slot_word[2];
  assign instruction_4   = slot_word[3];
  assign mult_ins_signal = any_mul | div_busy;
  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;

endmodule

// File: tb/tb_mult_div_issue_tracker.sv
module tb_mult_div_issue_tracker;

  localparam int DIV_LAT = 32;
  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [31:0] issue_instruction;
  logic        issue_ready;
  logic        flush;
  logic        mult_start;
  logic        mult_is_div;
  logic [31:0] instruction_1, instruction_2, instruction_3, instruction_4;
  logic        mult_ins_signal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_ready;

  mult_div_issue_tracker dut (
    .clock             (clock),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_instruction (issue_instruction),
    .issue_ready       (issue_ready),
    .flush             (flush),
    .mult_start        (mult_start),
    .mult_is_div       (mult_is_div),
    .instruction_1     (instruction_1),
    .instruction_2     (instruction_2),
    .instruction_3     (instruction_3),
    .instruction_4     (instruction_4),
    .mult_ins_signal   (mult_ins_signal),
    .wb_valid          (wb_valid),
    .wb_rd             (wb_rd),
    .wb_ready          (wb_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] aluop, input logic [4:0] rd,
                                     input logic [14:0] tag);
    return {5'b00000, rd, tag, aluop, 2'b00};
  endfunction

  function automatic bit w_mul(input logic [31:0] w);
    return (w[31:27] == 5'b0) && (w[6:2] == MUL);
  endfunction

  function automatic bit w_div(input logic [31:0] w);
    return (w[31:27] == 5'b0) && (w[6:2] == DIV);
  endfunction

  // Model: in-flight multiplies are kept oldest-first, each with an age in
  // cycles. Ages 1..4 are the slots, and age 5 means the op waits for
  // writeback. A divide is modelled as a running count plus a done flag.
  logic [31:0] mq_word[$];
  int          mq_age[$];
  bit          dv_on, dv_done;
  int          dv_cnt;
  logic [31:0] dv_word;

  bit          e_ready, e_start, e_isdiv, e_ins, e_wbv;
  logic [4:0]  e_rd;
  logic [31:0] e_slot[4];

  task automatic model_expect();
    bit any_mul;
    logic [31:0] w;
    any_mul = 0;
    e_wbv = 0;
    e_rd = '0;
    for (int i = 0; i < 4; i++) e_slot[i] = '0;
    for (int i = 0; i < mq_age.size(); i++) begin
      w = mq_word[i];
      if (mq_age[i] <= 4) begin
        any_mul = 1;
        e_slot[mq_age[i]-1] = w;
      end else begin
        e_wbv = 1;
        e_rd = w[26:22];
      end
    end
    if (dv_on && !dv_done) e_slot[0] = dv_word;
    if (dv_done) begin
      e_wbv = 1;
      w = dv_word;
      e_rd = w[26:22];
    end
    e_ins   = any_mul || dv_on;
    e_ready = !dv_on && !(e_wbv && !wb_ready) &&
              !(issue_valid && w_div(issue_instruction) && any_mul);
    e_start = issue_valid && e_ready && (w_mul(issue_instruction) || w_div(issue_instruction))
              && !flush && !reset;
    e_isdiv = e_start && w_div(issue_instruction);
  endtask

  task automatic model_edge();
    bit was_done;
    model_expect();
    if (reset || flush) begin
      mq_word.delete();
      mq_age.delete();
      dv_on = 0; dv_done = 0; dv_cnt = 0;
    end else if (!(e_wbv && !wb_ready)) begin
      was_done = dv_done;
      if (e_wbv) begin
        if (was_done) begin
          dv_on = 0; dv_done = 0;
        end else begin
          void'(mq_word.pop_front());
          void'(mq_age.pop_front());
        end
      end
      for (int i = 0; i < mq_age.size(); i++) mq_age[i] = mq_age[i] + 1;
      if (dv_on && !was_done) begin
        if (dv_cnt == DIV_LAT) dv_done = 1;
        else dv_cnt++;
      end
      if (e_start) begin
        if (w_div(issue_instruction)) begin
          dv_on = 1; dv_done = 0; dv_cnt = 1; dv_word = issue_instruction;
        end else begin
          mq_word.push_back(issue_instruction);
          mq_age.push_back(1);
        end
      end
    end
  endtask

  initial begin
    dv_on = 0; dv_done = 0; dv_cnt = 0; dv_word = '0;
    forever begin
      @(posedge clock);
      model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        model_expect();
        chk("issue_ready", {31'b0, issue_ready}, {31'b0, e_ready});
        chk("mult_start", {31'b0, mult_start}, {31'b0, e_start});
        chk("mult_is_div", {31'b0, mult_is_div}, {31'b0, e_isdiv});
        chk("instruction_1", instruction_1, e_slot[0]);
        chk("instruction_2", instruction_2, e_slot[1]);
        chk("instruction_3", instruction_3, e_slot[2]);
        chk("instruction_4", instruction_4, e_slot[3]);
        chk("mult_ins_signal", {31'b0, mult_ins_signal}, {31'b0, e_ins});
        chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_wbv});
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, e_rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] wa, wb, wc, wd, we;
  int n_low;

  initial begin
    reset = 1; issue_valid = 0; issue_instruction = '0; flush = 0; wb_ready = 1;
    step();
    chk_en = 1;
    step();
    chk("rst issue_ready", {31'b0, issue_ready}, 32'd1);
    chk("rst wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst mult_ins", {31'b0, mult_ins_signal}, 32'd0);
    chk("rst instr1", instruction_1, 32'd0);
    reset = 0;

    // single mul rd=5, then a new issue in the same cycle as its writeback
    wa = mk(MUL, 5'd5, 15'h101);
    issue_valid = 1; issue_instruction = wa;
    step();
    issue_valid = 0;
    chk("t1 instr1 +1", instruction_1, 32'h0140_8098);
    step(); step(); step();
    chk("t1 instr4 +4", instruction_4, wa);
    chk("t1 instr1 +4", instruction_1, 32'd0);
    step();
    chk("t1 wb_valid +5", {31'b0, wb_valid}, 32'd1);
    chk("t1 wb_rd +5", {27'b0, wb_rd}, 32'd5);
    wb = mk(MUL, 5'd6, 15'h102);
    issue_valid = 1; issue_instruction = wb;
    #2;
    chk("t1 start with wb", {31'b0, mult_start}, 32'd1);
    step();
    issue_valid = 0;
    chk("t1 wb cleared", {31'b0, wb_valid}, 32'd0);
    chk("t1 second instr1", instruction_1, wb);
    repeat (5) step();

    // four back-to-back muls
    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1; issue_instruction = mk(MUL, 5'(i), 15'(i));
      step();
    end
    issue_valid = 0;
    step();
    for (int k = 1; k <= 4; k++) begin
      chk("t2 wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("t2 wb_rd", {27'b0, wb_rd}, k);
      step();
    end
    chk("t2 drained", {31'b0, wb_valid}, 32'd0);

    // div rd=9 with a mul offered during the divide
    issue_valid = 1; issue_instruction = mk(DIV, 5'd9, 15'h9);
    step();
    issue_instruction = mk(MUL, 5'd7, 15'h7);
    n_low = 0;
    for (int c = 1; c <= 60; c++) begin
      #2;
      if (c == 33) begin
        chk("t3 wb_valid +33", {31'b0, wb_valid}, 32'd1);
        chk("t3 wb_rd +33", {27'b0, wb_rd}, 32'd9);
      end
      if (issue_ready) break;
      n_low++;
      step();
    end
    chk("t3 ready low cycles", n_low, 32'd33);
    chk("t3 mul start after div", {31'b0, mult_start}, 32'd1);
    step();
    issue_valid = 0;
    repeat (6) step();

    // writeback stall with two muls in flight
    wa = mk(MUL, 5'd11, 15'h11);
    wb = mk(MUL, 5'd12, 15'h12);
    issue_valid = 1; issue_instruction = wa;
    step();
    issue_instruction = wb;
    step();
    issue_valid = 0;
    repeat (3) step();
    chk("t4 wb_rd first", {27'b0, wb_rd}, 32'd11);
    wb_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4 frozen wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("t4 frozen wb_rd", {27'b0, wb_rd}, 32'd11);
      chk("t4 frozen instr4", instruction_4, wb);
      chk("t4 frozen ready", {31'b0, issue_ready}, 32'd0);
    end
    wb_ready = 1;
    step();
    chk("t4 drain second", {27'b0, wb_rd}, 32'd12);
    step();
    chk("t4 drained", {31'b0, wb_valid}, 32'd0);

    // flush with three muls in flight, plus an issue that the flush ignores
    wc = mk(MUL, 5'd13, 15'h13);
    wd = mk(MUL, 5'd14, 15'h14);
    we = mk(MUL, 5'd15, 15'h15);
    issue_valid = 1; issue_instruction = wc; step();
    issue_instruction = wd; step();
    issue_instruction = we; step();
    chk("t5 instr3 before flush", instruction_3, wc);
    issue_instruction = mk(MUL, 5'd20, 15'h20);
    flush = 1;
    #2;
    chk("t5 start during flush", {31'b0, mult_start}, 32'd0);
    step();
    flush = 0; issue_valid = 0;
    chk("t5 instr1", instruction_1, 32'd0);
    chk("t5 instr2", instruction_2, 32'd0);
    chk("t5 instr3", instruction_3, 32'd0);
    chk("t5 instr4", instruction_4, 32'd0);
    chk("t5 mult_ins", {31'b0, mult_ins_signal}, 32'd0);
    chk("t5 wb_valid", {31'b0, wb_valid}, 32'd0);
    repeat (4) step();
    chk("t5 no late wb", {31'b0, wb_valid}, 32'd0);

    // words that are not mul/div are refused
    issue_valid = 1; issue_instruction = {5'b00001, 5'd3, 15'h0, MUL, 2'b00};
    #2;
    chk("t7 bad opcode start", {31'b0, mult_start}, 32'd0);
    chk("t7 bad opcode ready", {31'b0, issue_ready}, 32'd1);
    step();
    issue_instruction = mk(5'b00101, 5'd3, 15'h0);
    #2;
    chk("t7 bad aluop start", {31'b0, mult_start}, 32'd0);
    step();
    issue_valid = 0;
    chk("t7 nothing entered", instruction_1, 32'd0);

    // reset at divide cycle 10
    issue_valid = 1; issue_instruction = mk(DIV, 5'd9, 15'h99);
    step();
    issue_valid = 0;
    repeat (9) step();
    chk("t6 div running", {31'b0, mult_ins_signal}, 32'd1);
    reset = 1;
    step();
    reset = 0;
    chk("t6 ready", {31'b0, issue_ready}, 32'd1);
    chk("t6 instr1", instruction_1, 32'd0);
    chk("t6 mult_ins", {31'b0, mult_ins_signal}, 32'd0);
    chk("t6 wb_valid", {31'b0, wb_valid}, 32'd0);
    issue_valid = 1; issue_instruction = mk(MUL, 5'd21, 15'h21);
    step();
    issue_valid = 0;
    repeat (7) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
